// File: rtl/mixer_pkg.sv
// mixer_pkg: round-mode constants and saturation helpers
// shared by the pipelined fixed-point mixer.
package mixer_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  localparam int MAX_DW = 64;
  localparam int WIDE_W = 2 * MAX_DW;

  function automatic logic signed [WIDE_W-1:0] sat_max(
    input int dw
  );
    logic signed [WIDE_W-1:0] one;
    one = {{(WIDE_W-1){1'b0}}, 1'b1};
    return (one <<< (dw - 1)) - one;
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_min(
    input int dw
  );
    logic signed [WIDE_W-1:0] one;
    one = {{(WIDE_W-1){1'b0}}, 1'b1};
    return -(one <<< (dw - 1));
  endfunction

  function automatic logic [MAX_DW-1:0] saturate(
    input  logic signed [WIDE_W-1:0] r,
    input  int                       dw,
    output logic                     ovf,
    output logic                     unf
  );
    logic signed [WIDE_W-1:0] mx;
    logic signed [WIDE_W-1:0] mn;
    logic [MAX_DW-1:0]        y;
    mx  = sat_max(dw);
    mn  = sat_min(dw);
    ovf = r > mx;
    unf = r < mn;
    unique case (1'b1)
      ovf:     y = mx[MAX_DW-1:0];
      unf:     y = mn[MAX_DW-1:0];
      default: y = r[MAX_DW-1:0];
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mixer_lane.sv
// mixer_lane: one lane of the mixer datapath,
// operand reg, product reg, round/shift/saturate reg.
module mixer_lane
  import mixer_pkg::*;
#(
  parameter int DW         = 64,
  parameter int FRAC       = 43,
  parameter int ROUND_MODE = ROUND_TRUNC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y,
  output logic          ovf,
  output logic          unf
);

  localparam logic signed [2*DW-1:0] RND =
    {{(2*DW-1){1'b0}}, 1'b1} << (FRAC - 1);

  logic signed [DW-1:0]     a1;
  logic signed [DW-1:0]     b1;
  logic signed [2*DW-1:0]   p2;
  logic signed [2*DW-1:0]   pr;
  logic signed [2*DW-1:0]   r;
  logic signed [WIDE_W-1:0] rx;
  logic [MAX_DW-1:0]        sv;
  logic                     so;
  logic                     su;

  // S1 captures operands, S2 the full-width signed product
  always_ff @(posedge clk) begin
    if (en) begin
      a1 <= a;
      b1 <= b;
      p2 <= (2*DW)'(a1) * (2*DW)'(b1);
    end
  end

  // round, rescale and clamp the product
  always_comb begin
    pr = p2 + ((ROUND_MODE == ROUND_HALF_UP) ? RND : '0);
    r  = pr >>> FRAC;
    rx = WIDE_W'(r);
    so = 1'b0;
    su = 1'b0;
    sv = saturate(rx, DW, so, su);
  end

  // S3 registers the result and its saturation flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (en) begin
      y   <= sv[DW-1:0];
      ovf <= so;
      unf <= su;
    end
  end

endmodule

// File: rtl/mixer_pipe.sv
// mixer_pipe: 3-stage multi-lane saturating multiplier
// with valid/ready flow, sticky flags and a sat counter.
module mixer_pipe
  import mixer_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int DATA_FRAC_WIDTH = 43,
  parameter int NUM_CH          = 2,
  parameter int ROUND_MODE      = ROUND_TRUNC,
  parameter int SAT_CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_a,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out,
  output logic [NUM_CH-1:0]            overflow,
  output logic [NUM_CH-1:0]            underflow,
  output logic [NUM_CH-1:0]            sticky_ovf,
  output logic [NUM_CH-1:0]            sticky_unf,
  input  logic                         clr_sticky,
  output logic [SAT_CNT_W-1:0]         sat_count
);

  logic v1;
  logic v2;
  logic v3;
  logic stall;
  logic en;
  logic xfer;
  logic sat_ev;

  assign stall     = v3 && !out_ready;
  assign en        = !stall;
  assign in_ready  = !stall;
  assign out_valid = v3;
  assign xfer      = v3 && out_ready;
  assign sat_ev    = xfer && (|(overflow | underflow));

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    mixer_lane #(
      .DW         (DATA_WIDTH),
      .FRAC       (DATA_FRAC_WIDTH),
      .ROUND_MODE (ROUND_MODE)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a     (in_a[k*DATA_WIDTH +: DATA_WIDTH]),
      .b     (in_b[k*DATA_WIDTH +: DATA_WIDTH]),
      .y     (out[k*DATA_WIDTH +: DATA_WIDTH]),
      .ovf   (overflow[k]),
      .unf   (underflow[k])
    );
  end

  // valid bits advance in lockstep; bubbles are kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // sticky flags: a same-cycle event beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= '0;
      sticky_unf <= '0;
    end else if (clr_sticky || xfer) begin
      sticky_ovf <= (clr_sticky ? '0 : sticky_ovf)
                  | (xfer ? overflow : '0);
      sticky_unf <= (clr_sticky ? '0 : sticky_unf)
                  | (xfer ? underflow : '0);
    end
  end

  // count saturating transfers, pinned at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (clr_sticky) begin
      sat_count <= sat_ev ? SAT_CNT_W'(1) : '0;
    end else if (sat_ev && !(&sat_count)) begin
      sat_count <= sat_count + SAT_CNT_W'(1);
    end
  end

endmodule
